writeback_buffer: RTL and testbench

WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

---
 rtl/writeback_buffer_if.sv | 41 ++++
 rtl/writeback_buffer.sv | 109 ++++++++++
 tb/tb_writeback_buffer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/writeback_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : writeback_buffer_if
// Description : Result-push, register-file write and forwarding-snoop bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface writeback_buffer_if #(
  parameter int DW = 12,
  parameter int AW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          wb_stall;
  logic          flush;
  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic          fwd1_hit;
  logic          fwd2_hit;
  logic [DW-1:0] fwd1_data;
  logic [DW-1:0] fwd2_data;
  logic [AW:0]   count;
  logic          empty;

  modport slave (
    input  in_valid, in_addr, in_data, wb_stall, flush, ra1, ra2,
    output in_ready, we3, wa3, wd3, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
           count, empty
  );

  modport master (
    output in_valid, in_addr, in_data, wb_stall, flush, ra1, ra2,
    input  in_ready, we3, wa3, wd3, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
           count, empty
  );
endinterface
`default_nettype wire

// File: rtl/writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module      : writeback_buffer
// Description : In-order write-back FIFO draining into a register-file write
//               port, with youngest-match forwarding on two read addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_buffer #(
  parameter int DEPTH = 4,
  parameter int DW    = 12,
  parameter int AW    = 2
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  writeback_buffer_if.slave  bus
);
  localparam int              c_ptr_w   = $clog2(DEPTH);
  localparam logic [AW:0]     c_depth   = (AW+1)'(DEPTH);
  localparam logic [AW:0]     c_cnt_one = (AW+1)'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [AW-1:0]   c_pc_addr = AW'(1);

  logic [AW-1:0]      r_addr [DEPTH];
  logic [DW-1:0]      r_data [DEPTH];
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [AW:0]        r_count;

  logic               w_empty;
  logic               w_in_ready;
  logic               w_push;
  logic               w_we3;
  logic               w_pop;
  logic [c_ptr_w-1:0] w_idx;
  logic               w_fwd1_hit;
  logic               w_fwd2_hit;
  logic [DW-1:0]      w_fwd1_data;
  logic [DW-1:0]      w_fwd2_data;

  assign w_empty    = (r_count == '0);
  // No pass-through: a full buffer refuses even while it is draining.
  assign w_in_ready = (r_count != c_depth) && !bus.flush;
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_we3      = !w_empty && !bus.wb_stall && !bus.flush;
  assign w_pop      = w_we3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + c_ptr_one;
      if (w_pop)  r_head <= r_head + c_ptr_one;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= bus.in_addr;
      r_data[r_tail] <= bus.in_data;
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    w_idx       = r_head;
    w_fwd1_hit  = 1'b0;
    w_fwd2_hit  = 1'b0;
    w_fwd1_data = '0;
    w_fwd2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + c_ptr_w'(i);
      if (i < int'(r_count)) begin
        if ((r_addr[w_idx] == bus.ra1) && (bus.ra1 != c_pc_addr)) begin
          w_fwd1_hit  = 1'b1;
          w_fwd1_data = r_data[w_idx];
        end
        if ((r_addr[w_idx] == bus.ra2) && (bus.ra2 != c_pc_addr)) begin
          w_fwd2_hit  = 1'b1;
          w_fwd2_data = r_data[w_idx];
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.we3       = w_we3;
  assign bus.wa3       = w_empty ? '0 : r_addr[r_head];
  assign bus.wd3       = w_empty ? '0 : r_data[r_head];
  assign bus.fwd1_hit  = w_fwd1_hit;
  assign bus.fwd2_hit  = w_fwd2_hit;
  assign bus.fwd1_data = w_fwd1_data;
  assign bus.fwd2_data = w_fwd2_data;
  assign bus.count     = r_count;
  assign bus.empty     = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_buffer
// Description : Randomized and directed bench against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_buffer;
  localparam int DEPTH = 4;
  localparam int DW    = 12;
  localparam int AW    = 2;

  typedef struct {
    int addr;
    int data;
  } ent_t;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;
  ent_t q[$];

  writeback_buffer_if #(.DW(DW), .AW(AW)) bus ();

  writeback_buffer #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fwd_hit(input int ra);
    if (ra == 1) return 0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].addr == ra) return 1;
    return 0;
  endfunction

  function automatic int fwd_data(input int ra);
    if (ra == 1) return 0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].addr == ra) return q[i].data;
    return 0;
  endfunction

  task automatic check_all();
    int sz;
    sz = q.size();
    chk_val("count",    32'(bus.count),    32'(sz));
    chk_val("empty",    32'(bus.empty),    32'(sz == 0));
    chk_val("in_ready", 32'(bus.in_ready), 32'((sz != DEPTH) && !bus.flush));
    chk_val("we3",      32'(bus.we3),      32'((sz != 0) && !bus.wb_stall && !bus.flush));
    chk_val("wa3",      32'(bus.wa3),      32'((sz != 0) ? q[0].addr : 0));
    chk_val("wd3",      32'(bus.wd3),      32'((sz != 0) ? q[0].data : 0));
    chk_val("fwd1_hit", 32'(bus.fwd1_hit), 32'(fwd_hit(int'(bus.ra1))));
    chk_val("fwd1_dat", 32'(bus.fwd1_data),32'(fwd_data(int'(bus.ra1))));
    chk_val("fwd2_hit", 32'(bus.fwd2_hit), 32'(fwd_hit(int'(bus.ra2))));
    chk_val("fwd2_dat", 32'(bus.fwd2_data),32'(fwd_data(int'(bus.ra2))));
  endtask

  // Drive one cycle's inputs (called at the falling edge), then compare.
  task automatic apply(input int v, input int a, input int d, input int st,
                       input int fl, input int r1, input int r2);
    bus.in_valid = v[0];
    bus.in_addr  = AW'(a);
    bus.in_data  = DW'(d);
    bus.wb_stall = st[0];
    bus.flush    = fl[0];
    bus.ra1      = AW'(r1);
    bus.ra2      = AW'(r2);
    #1;
    check_all();
  endtask

  task automatic tick();
    bit   push;
    bit   pop;
    ent_t e;
    push = bus.in_valid && (q.size() != DEPTH) && !bus.flush;
    pop  = (q.size() != 0) && !bus.wb_stall && !bus.flush;
    e.addr = int'(bus.in_addr);
    e.data = int'(bus.in_data);
    @(posedge clk);
    if (reset_n) begin
      if (bus.flush) q.delete();
      else begin
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 0);
    chk_val("rst_count", 32'(bus.count), 0);
    chk_val("rst_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;
    apply(0, 0, 0, 0, 0, 2, 3);
    tick();

    // Single push drains one cycle later.
    apply(1, 2, 12'hABC, 0, 0, 0, 0);
    tick();
    apply(0, 0, 0, 0, 0, 2, 0);
    chk_val("lat_we3", 32'(bus.we3), 1);
    chk_val("lat_wa3", 32'(bus.wa3), 2);
    chk_val("lat_wd3", 32'(bus.wd3), 32'h0ABC);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk_val("lat_empty", 32'(bus.empty), 1);
    tick();

    // Fill under stall, youngest-match forwarding, PC address excluded.
    apply(1, 0, 1, 1, 0, 0, 0); tick();
    apply(1, 2, 2, 1, 0, 0, 0); tick();
    apply(1, 3, 3, 1, 0, 0, 0); tick();
    apply(1, 2, 4, 1, 0, 2, 2); tick();
    apply(1, 1, 5, 1, 0, 2, 1);
    chk_val("full_count", 32'(bus.count), 4);
    chk_val("full_ready", 32'(bus.in_ready), 0);
    chk_val("full_f1hit", 32'(bus.fwd1_hit), 1);
    chk_val("full_f1dat", 32'(bus.fwd1_data), 4);
    chk_val("full_f2hit", 32'(bus.fwd2_hit), 0);
    tick();

    // Release stall: in-order drain, no pass-through while full.
    apply(1, 3, 9, 0, 0, 3, 0);
    chk_val("drain0_wd3", 32'(bus.wd3), 1);
    chk_val("drain0_rdy", 32'(bus.in_ready), 0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk_val("drain1_wd3", 32'(bus.wd3), 2);
    chk_val("drain1_rdy", 32'(bus.in_ready), 1);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0); chk_val("drain2_wd3", 32'(bus.wd3), 3); tick();
    apply(0, 0, 0, 0, 0, 0, 0); chk_val("drain3_wd3", 32'(bus.wd3), 4); tick();
    apply(0, 0, 0, 0, 0, 0, 0); chk_val("drain_empty", 32'(bus.empty), 1); tick();

    // Steady push+pop at count 2 wraps pointers and preserves order.
    apply(1, 1, 12'h100, 1, 0, 0, 0); tick();
    apply(1, 2, 12'h101, 1, 0, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      apply(1, i % 4, 12'h200 + i, 0, 0, i % 4, 3);
      chk_val("pp_count", 32'(bus.count), 2);
      chk_val("pp_wd3", 32'(bus.wd3), (i == 0) ? 32'h100 : (i == 1) ? 32'h101 : 32'(12'h200 + i - 2));
      tick();
    end
    apply(0, 0, 0, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 0); tick();

    // Flush with a push offered.
    apply(1, 1, 7, 1, 0, 0, 0); tick();
    apply(1, 2, 8, 1, 0, 0, 0); tick();
    apply(1, 3, 9, 1, 0, 0, 0); tick();
    apply(1, 0, 10, 0, 1, 3, 0);
    chk_val("fl_we3", 32'(bus.we3), 0);
    chk_val("fl_ready", 32'(bus.in_ready), 0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk_val("fl_count", 32'(bus.count), 0);
    tick();

    // Asynchronous reset mid-cycle with two entries pending.
    apply(1, 2, 11, 1, 0, 0, 0); tick();
    apply(1, 3, 12, 1, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 2, 3);
    #1 reset_n = 1'b0;
    q.delete();
    #1;
    chk_val("ar_count", 32'(bus.count), 0);
    chk_val("ar_we3", 32'(bus.we3), 0);
    chk_val("ar_f1hit", 32'(bus.fwd1_hit), 0);
    bus.wb_stall = 1'b0;
    @(negedge clk);
    check_all();
    #2 reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0, 2, 3);
      chk_val("ar_nowrite", 32'(bus.we3), 0);
      tick();
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      apply(int'($urandom_range(0, 9) < 7), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 4095)), int'($urandom_range(0, 9) < 3),
            int'($urandom_range(0, 99) < 4), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
